// File: rtl/ixc_stage_pkg.sv
// Shared types and constants for the ixc skid stage and its statistics counter.
package ixc_stage_pkg;

   localparam int unsigned IXC_DATA_W = 13;
   localparam int unsigned IXC_CNT_W  = 16;

   typedef logic [IXC_DATA_W-1:0] ixc_data_t;

   // Encoding mirrors {skid_v, main_v}; 2'b10 is never produced.
   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      ONE   = 2'b01,
      FULL  = 2'b11
   } ixc_skid_state_e;

endpackage

// File: rtl/ixc_skid_reg_13_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module ixc_sat_cnt
   import ixc_stage_pkg::*;
#(
   parameter int unsigned W = IXC_CNT_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   localparam logic [W-1:0] STEP = {{(W-1){1'b0}}, 1'b1};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != '1)) begin
         cnt <= cnt + STEP;
      end
   end

endmodule

// File: rtl/ixc_skid_reg_13.sv
// Two-entry registered valid/ready skid stage feeding the 13-bit ixc_assign template.
// Optional transfer counter compiled in with IXC_SKID_STATS_EN.
module ixc_skid_reg_13
   import ixc_stage_pkg::*;
#(
   parameter int unsigned WIDTH = IXC_DATA_W,
   parameter int unsigned CNT_W = IXC_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready
`ifdef IXC_SKID_STATS_EN
   ,
   output logic [CNT_W-1:0] xfer_cnt
`endif
);

   ixc_skid_state_e  state;
   ixc_skid_state_e  state_nxt;
   logic [WIDTH-1:0] main_d;
   logic [WIDTH-1:0] skid_d;
   logic             main_v;
   logic             skid_v;
   logic             in_fire;
   logic             out_fire;
   logic             load_main;
   logic             main_from_skid;
   logic             load_skid;

   assign main_v    = (state == ONE) || (state == FULL);
   assign skid_v    = (state == FULL);
   assign out_valid = main_v;
   assign out_data  = main_d;
   assign in_ready  = !skid_v;
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      load_main      = 1'b0;
      main_from_skid = 1'b0;
      load_skid      = 1'b0;
      case (state)
         EMPTY: begin
            if (in_fire) begin
               load_main = 1'b1;
               state_nxt = ONE;
            end
         end
         ONE: begin
            if (in_fire && out_fire) begin
               load_main = 1'b1;
            end else if (in_fire) begin
               load_skid = 1'b1;
               state_nxt = FULL;
            end else if (out_fire) begin
               state_nxt = EMPTY;
            end
         end
         FULL: begin
            if (out_fire) begin
               load_main      = 1'b1;
               main_from_skid = 1'b1;
               state_nxt      = ONE;
            end
         end
         default: state_nxt = EMPTY;
      endcase
      // Flush drops everything, including a word accepted this same cycle.
      if (flush) begin
         state_nxt = EMPTY;
         load_main = 1'b0;
         load_skid = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_d <= '0;
         skid_d <= '0;
      end else begin
         if (load_main) begin
            main_d <= main_from_skid ? skid_d : in_data;
         end
         if (load_skid) begin
            skid_d <= in_data;
         end
      end
   end

`ifdef IXC_SKID_STATS_EN
   ixc_sat_cnt #(
      .W (CNT_W)
   ) u_xfer_cnt (
      .clk (clk),
      .rst (rst),
      .clr (flush),
      .inc (out_fire),
      .cnt (xfer_cnt)
   );
`endif

endmodule

// File: tb/tb_ixc_skid_reg_13.sv
// Self-checking bench for ixc_skid_reg_13: vector table, corner sequences, random traffic vs queue model.
module tb_ixc_skid_reg_13;

   localparam int unsigned W      = 13;
   localparam int unsigned TB_CW  = 4;
   localparam int          CMAX   = (1 << TB_CW) - 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          flush;
   logic          in_valid;
   logic [W-1:0]  in_data;
   logic          in_ready;
   logic          out_valid;
   logic [W-1:0]  out_data;
   logic          out_ready;
`ifdef IXC_SKID_STATS_EN
   logic [TB_CW-1:0] xfer_cnt;
`endif

   int checks   = 0;
   int failures = 0;

   logic [W-1:0] mq[$];
   int           mcnt = 0;

   typedef struct {
      logic         fl;
      logic         iv;
      logic [W-1:0] d;
      logic         ordy;
      logic         ev;
      logic [W-1:0] ed;
      logic         er;
   } vec_t;

   vec_t tbl[10];

   ixc_skid_reg_13 #(
      .WIDTH (W),
      .CNT_W (TB_CW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready)
`ifdef IXC_SKID_STATS_EN
      ,
      .xfer_cnt  (xfer_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Advance one clock; the model is a bounded FIFO of depth 2.
   task automatic tick();
      bit inf;
      bit outf;
      inf  = in_valid && (mq.size() < 2);
      outf = out_ready && (mq.size() > 0);
      @(posedge clk);
      #1;
      if (flush) begin
         mq.delete();
         mcnt = 0;
      end else begin
         if (outf) begin
            void'(mq.pop_front());
            if (mcnt != CMAX) mcnt++;
         end
         if (inf) mq.push_back(in_data);
      end
   endtask

   task automatic cmp_model(input string tag);
      chk({tag, "_out_valid"}, 32'(out_valid), 32'(mq.size() > 0));
      chk({tag, "_in_ready"}, 32'(in_ready), 32'(mq.size() < 2));
      if (mq.size() > 0) chk({tag, "_out_data"}, 32'(out_data), 32'(mq[0]));
`ifdef IXC_SKID_STATS_EN
      chk({tag, "_xfer_cnt"}, 32'(xfer_cnt), 32'(mcnt));
`endif
   endtask

   task automatic drive(input logic fl, input logic iv, input logic [W-1:0] d, input logic ordy);
      flush     = fl;
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
   endtask

   initial begin
      tbl[0] = '{1'b0, 1'b1, 13'h0001, 1'b1, 1'b1, 13'h0001, 1'b1};
      tbl[1] = '{1'b0, 1'b1, 13'h1FFF, 1'b1, 1'b1, 13'h1FFF, 1'b1};
      tbl[2] = '{1'b0, 1'b1, 13'h0ABC, 1'b1, 1'b1, 13'h0ABC, 1'b1};
      tbl[3] = '{1'b0, 1'b0, 13'h0000, 1'b1, 1'b0, 13'h0ABC, 1'b1};
      tbl[4] = '{1'b0, 1'b1, 13'h0111, 1'b0, 1'b1, 13'h0111, 1'b1};
      tbl[5] = '{1'b0, 1'b1, 13'h0222, 1'b0, 1'b1, 13'h0111, 1'b0};
      tbl[6] = '{1'b0, 1'b1, 13'h0333, 1'b0, 1'b1, 13'h0111, 1'b0};
      tbl[7] = '{1'b0, 1'b1, 13'h0333, 1'b1, 1'b1, 13'h0222, 1'b1};
      tbl[8] = '{1'b0, 1'b1, 13'h0333, 1'b1, 1'b1, 13'h0333, 1'b1};
      tbl[9] = '{1'b0, 1'b0, 13'h0000, 1'b1, 1'b0, 13'h0333, 1'b1};

      rst = 1'b1;
      drive(1'b0, 1'b0, '0, 1'b0);
      #1;
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_out_data", 32'(out_data), 32'd0);
      chk("reset_in_ready", 32'(in_ready), 32'd1);
`ifdef IXC_SKID_STATS_EN
      chk("reset_xfer_cnt", 32'(xfer_cnt), 32'd0);
`endif
      repeat (2) @(posedge clk);
      #3 rst = 1'b0;

      // Pass-through and backpressure vectors
      for (int i = 0; i < 10; i++) begin
         drive(tbl[i].fl, tbl[i].iv, tbl[i].d, tbl[i].ordy);
         tick();
         chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].ev));
         chk($sformatf("vec%0d_out_data", i), 32'(out_data), 32'(tbl[i].ed));
         chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].er));
      end

      // Stability under backpressure with toggling input data
      drive(1'b0, 1'b1, 13'h1234, 1'b0);
      tick();
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 1'b1, (i % 2 == 0) ? 13'h0F0F : 13'h10F0, 1'b0);
         tick();
         chk("stable_out_data", 32'(out_data), 32'h1234);
         chk("stable_out_valid", 32'(out_valid), 32'd1);
         cmp_model("stable");
      end

      // Flush from FULL with out_ready high: nothing delivered, count cleared
      drive(1'b1, 1'b1, 13'h0777, 1'b1);
      tick();
      chk("flush_out_valid", 32'(out_valid), 32'd0);
      chk("flush_in_ready", 32'(in_ready), 32'd1);
`ifdef IXC_SKID_STATS_EN
      chk("flush_xfer_cnt", 32'(xfer_cnt), 32'd0);
`endif
      cmp_model("flush");

      // Saturation: 20 back-to-back cycles yield 19 transfers
      for (int i = 0; i < 20; i++) begin
         drive(1'b0, 1'b1, W'(i + 1), 1'b1);
         tick();
         cmp_model("sat");
      end
`ifdef IXC_SKID_STATS_EN
      chk("sat_xfer_cnt", 32'(xfer_cnt), 32'hF);
`endif
      drive(1'b0, 1'b0, '0, 1'b1);
      tick();

      // Fill FULL with 0x0AA/0x155, then reset between clock edges
      drive(1'b0, 1'b1, 13'h00AA, 1'b0);
      tick();
      drive(1'b0, 1'b1, 13'h0155, 1'b0);
      tick();
      cmp_model("prefill");
      chk("prefill_in_ready", 32'(in_ready), 32'd0);
      #1 rst = 1'b1;
      #1;
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_out_data", 32'(out_data), 32'd0);
      chk("midrst_in_ready", 32'(in_ready), 32'd1);
`ifdef IXC_SKID_STATS_EN
      chk("midrst_xfer_cnt", 32'(xfer_cnt), 32'd0);
`endif
      mq.delete();
      mcnt = 0;
      @(posedge clk);
      #3 rst = 1'b0;

      // Random traffic against the queue model
      for (int i = 0; i < 400; i++) begin
         drive(($urandom_range(0, 99) < 3), $urandom_range(0, 1) == 1,
               W'($urandom), ($urandom_range(0, 9) < 7));
         tick();
         cmp_model("rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
